// File: rtl/rl_ram_1rw_arbiter_if.sv
// Requester-side bus of the 1RW RAM arbiter: per-port packed request fields plus grant/read-return.
// Handshake: req is the valid, gnt is the ready; an access transfers in the cycle where req[i] & gnt[i].
interface rl_ram_1rw_arbiter_if #(
    parameter int ABITS  = 10,
    parameter int DBITS  = 32,
    parameter int NPORTS = 2
);
    localparam int BBITS = (DBITS + 7) / 8;

    logic [NPORTS-1:0]       req;
    logic [NPORTS-1:0]       lock;
    logic [NPORTS-1:0]       we;
    logic [NPORTS*BBITS-1:0] be;
    logic [NPORTS*ABITS-1:0] addr;
    logic [NPORTS*DBITS-1:0] din;
    logic [NPORTS-1:0]       gnt;
    logic [NPORTS-1:0]       rvalid;
    logic [DBITS-1:0]        rdata;

    modport master (
        output req, lock, we, be, addr, din,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, be, addr, din,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rl_ram_1rw_arbiter.sv
// Shares one single-port RAM among NPORTS requesters with same-cycle grant, lock and tagged read return.
// Define RL_RAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module rl_ram_1rw_arbiter #(
    parameter int ABITS  = 10,
    parameter int DBITS  = 32,
    parameter int NPORTS = 2,
    localparam int BBITS = (DBITS + 7) / 8
) (
    input  logic                clk,
    input  logic                rstn,
    rl_ram_1rw_arbiter_if.slave bus,
    output logic [ABITS-1:0]    ram_addr,
    output logic                ram_we,
    output logic [BBITS-1:0]    ram_be,
    output logic [DBITS-1:0]    ram_din,
    input  logic [DBITS-1:0]    ram_dout
);
    localparam int IW = $clog2(NPORTS);

    logic [NPORTS-1:0] r_rvalid;
    logic              r_own_vld;
    logic [IW-1:0]     r_last_idx;

    logic [NPORTS-1:0] w_gnt;
    logic [IW-1:0]     w_gidx;
    logic              w_any;
    logic [IW-1:0]     w_sel;
    logic [ABITS-1:0]  w_addr_a [NPORTS];
    logic [DBITS-1:0]  w_din_a  [NPORTS];
    logic [BBITS-1:0]  w_be_a   [NPORTS];

`ifdef RL_RAM_ARB_RR_EN
    localparam logic [IW:0] NP_W = (IW+1)'(NPORTS);
    logic [IW-1:0] r_rr_ptr;
    logic [IW:0]   w_rr_sum;
`endif

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            w_addr_a[k] = bus.addr[k*ABITS +: ABITS];
            w_din_a[k]  = bus.din[k*DBITS +: DBITS];
            w_be_a[k]   = bus.be[k*BBITS +: BBITS];
        end
    end

    // The lock owner is always the last granted port, so r_last_idx doubles as the owner index.
    always_comb begin
        w_gnt  = '0;
        w_gidx = '0;
        w_any  = 1'b0;
`ifdef RL_RAM_ARB_RR_EN
        w_rr_sum = '0;
`endif
        if (rstn) begin
            if (r_own_vld && bus.req[r_last_idx]) begin
                w_any  = 1'b1;
                w_gidx = r_last_idx;
            end else begin
`ifdef RL_RAM_ARB_RR_EN
                for (int k = 0; k < NPORTS; k++) begin
                    w_rr_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
                    if (w_rr_sum >= NP_W) w_rr_sum = w_rr_sum - NP_W;
                    if (!w_any && bus.req[w_rr_sum[IW-1:0]]) begin
                        w_any  = 1'b1;
                        w_gidx = w_rr_sum[IW-1:0];
                    end
                end
`else
                for (int k = NPORTS - 1; k >= 0; k--) begin
                    if (bus.req[k]) begin
                        w_any  = 1'b1;
                        w_gidx = IW'(k);
                    end
                end
`endif
            end
            if (w_any) w_gnt[w_gidx] = 1'b1;
        end
    end

    // With no grant the address/data lines keep following the last granted port.
    assign w_sel    = w_any ? w_gidx : r_last_idx;
    assign ram_addr = w_addr_a[w_sel];
    assign ram_din  = w_din_a[w_sel];
    assign ram_we   = w_any & bus.we[w_gidx];
    assign ram_be   = w_any ? w_be_a[w_gidx] : '0;

    assign bus.gnt    = w_gnt;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = ram_dout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rvalid   <= '0;
            r_own_vld  <= 1'b0;
            r_last_idx <= '0;
        end else begin
            r_rvalid  <= w_gnt & ~bus.we;
            r_own_vld <= w_any & bus.lock[w_gidx];
            if (w_any) r_last_idx <= w_gidx;
        end
    end

`ifdef RL_RAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (w_any && !bus.lock[w_gidx]) begin
            r_rr_ptr <= (w_gidx == IW'(NPORTS - 1)) ? '0 : w_gidx + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rl_ram_1rw_arbiter.sv
// Bench for rl_ram_1rw_arbiter: directed literal checks plus random traffic against a rule-level model.
module tb_rl_ram_1rw_arbiter;
    localparam int AB = 10;
    localparam int DB = 32;
    localparam int NP = 2;
    localparam int BB = 4;

    logic          clk;
    logic          rstn;
    logic [AB-1:0] ram_addr;
    logic          ram_we;
    logic [BB-1:0] ram_be;
    logic [DB-1:0] ram_din;
    logic [DB-1:0] ram_dout;

    int total = 0;
    int bad   = 0;

    rl_ram_1rw_arbiter_if #(.ABITS(AB), .DBITS(DB), .NPORTS(NP)) bus_if ();

    rl_ram_1rw_arbiter #(.ABITS(AB), .DBITS(DB), .NPORTS(NP)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus_if),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_be   (ram_be),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro: byte-enabled write, registered read
    logic [DB-1:0] ram_mem [0:(1<<AB)-1];
    initial for (int i = 0; i < (1 << AB); i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < BB; b++)
                if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic idle();
        bus_if.req  = '0;
        bus_if.lock = '0;
        bus_if.we   = '0;
        bus_if.be   = '0;
        bus_if.addr = '0;
        bus_if.din  = '0;
    endtask

    task automatic drive(input int p, input bit w, input logic [AB-1:0] a,
                         input logic [DB-1:0] d, input logic [BB-1:0] b, input bit l);
        bus_if.req[p]             = 1'b1;
        bus_if.we[p]              = w;
        bus_if.lock[p]            = l;
        bus_if.addr[p*AB +: AB]   = a;
        bus_if.din[p*DB +: DB]    = d;
        bus_if.be[p*BB +: BB]     = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: rule-level model of ownership, pointer, memory and read returns
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] m_mem [0:(1<<AB)-1];
    bit            m_own_vld = 0;
    int            m_own     = 0;
    int            m_ptr     = 0;
    int            m_last    = 0;
    logic [NP-1:0] m_rv      = '0;

    function automatic int model_pick();
        if (!rstn) return -1;
        if (m_own_vld && bus_if.req[m_own]) return m_own;
`ifdef RL_RAM_ARB_RR_EN
        for (int k = 0; k < NP; k++)
            if (bus_if.req[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
`else
        for (int p = 0; p < NP; p++)
            if (bus_if.req[p]) return p;
`endif
        return -1;
    endfunction

    initial begin
        int            g;
        int            sel;
        logic [AB-1:0] a;
        logic [DB-1:0] d;
        logic [BB-1:0] b;
        for (int i = 0; i < (1 << AB); i++) m_mem[i] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            g   = model_pick();
            sel = (g >= 0) ? g : m_last;
            check("m_gnt", bus_if.gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
            check("m_ram_we", ram_we, (g >= 0) ? bus_if.we[g] : 1'b0);
            check("m_ram_be", ram_be, (g >= 0) ? bus_if.be[g*BB +: BB] : '0);
            check("m_ram_addr", ram_addr, bus_if.addr[sel*AB +: AB]);
            check("m_ram_din", ram_din, bus_if.din[sel*DB +: DB]);
            check("m_rvalid", bus_if.rvalid, m_rv);
            if (m_rv != 0) begin
                if (exp_q.size() == 0) check("m_rdata_q", 32'd0, 32'd1);
                else check("m_rdata", bus_if.rdata, exp_q.pop_front());
            end
            if (!rstn) begin
                m_rv = '0;
                exp_q.delete();
                m_own_vld = 0;
                m_ptr = 0;
                m_last = 0;
            end else begin
                m_rv = '0;
                m_own_vld = 0;
                if (g >= 0) begin
                    a = bus_if.addr[g*AB +: AB];
                    d = bus_if.din[g*DB +: DB];
                    b = bus_if.be[g*BB +: BB];
                    if (bus_if.we[g]) begin
                        for (int k = 0; k < BB; k++)
                            if (b[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
                    end else begin
                        m_rv[g] = 1'b1;
                        exp_q.push_back(m_mem[a]);
                    end
                    m_own_vld = bus_if.lock[g];
                    m_own  = g;
                    m_last = g;
                    if (!bus_if.lock[g]) m_ptr = (g + 1) % NP;
                end
            end
        end
    end

    // stimulus with hand-computed literal expectations, then random traffic
    initial begin
        logic [NP-1:0] exp_c [4];
        logic [NP-1:0] gnt_prev;
`ifdef RL_RAM_ARB_RR_EN
        exp_c = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_c = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        idle();
        rstn = 1'b0;
        bus_if.req = 2'b11;
        bus_if.we  = 2'b11;
        bus_if.be  = '1;
        @(negedge clk);
        check("rst_gnt", bus_if.gnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_be", ram_be, 0);
        next_cycle();
        @(negedge clk);
        check("rst_rvalid", bus_if.rvalid, 0);
        next_cycle();

        // single write then read
        rstn = 1'b1;
        idle(); drive(0, 1, 10'h005, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        check("wr_gnt", bus_if.gnt, 2'b01);
        check("wr_ram_we", ram_we, 1);
        next_cycle();
        idle(); drive(0, 0, 10'h005, 32'h0, 4'h0, 0);
        @(negedge clk);
        check("rd_gnt", bus_if.gnt, 2'b01);
        check("wr_rvalid", bus_if.rvalid, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd_rvalid", bus_if.rvalid, 2'b01);
        check("rd_rdata", bus_if.rdata, 32'hDEADBEEF);
        next_cycle();

        // byte enables through port 1
        drive(1, 1, 10'h020, 32'h11223344, 4'hF, 0);
        next_cycle();
        idle(); drive(1, 1, 10'h020, 32'hFFFFFFFF, 4'b0010, 0);
        next_cycle();
        idle(); drive(1, 0, 10'h020, 32'h0, 4'h0, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("be_rvalid", bus_if.rvalid, 2'b10);
        check("be_rdata", bus_if.rdata, 32'h1122FF44);
        next_cycle();

        // contention after a reset cycle
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            drive(0, 0, 10'h005, 32'h0, 4'h0, 0);
            drive(1, 0, 10'h020, 32'h0, 4'h0, 0);
            @(negedge clk);
            check("cont_gnt", bus_if.gnt, exp_c[i]);
            if (i > 0) check("cont_rvalid", bus_if.rvalid, exp_c[i-1]);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("cont_rvalid_last", bus_if.rvalid, exp_c[3]);
        next_cycle();

        // lock held by port 1
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i > 0) drive(0, 0, 10'h005, 32'h0, 4'h0, 0);
            drive(1, 0, 10'h020, 32'h0, 4'h0, i < 3);
            @(negedge clk);
            check("lock_gnt", bus_if.gnt, (i < 4) ? 2'b10 : 2'b01);
            next_cycle();
        end

        // reset in the middle of a locked read stream
        idle(); drive(1, 0, 10'h020, 32'h0, 4'h0, 1);
        @(negedge clk);
        check("mid_gnt0", bus_if.gnt, 2'b10);
        next_cycle();
        rstn = 1'b0;
        idle(); drive(0, 0, 10'h005, 32'h0, 4'h0, 0); drive(1, 0, 10'h020, 32'h0, 4'h0, 1);
        @(negedge clk);
        check("mid_rst_gnt", bus_if.gnt, 0);
        check("mid_rst_rvalid", bus_if.rvalid, 2'b10);
        next_cycle();
        rstn = 1'b1;
        bus_if.lock = '0;
        @(negedge clk);
        check("mid_after_gnt", bus_if.gnt, 2'b01);
        check("mid_after_rvalid", bus_if.rvalid, 0);
        next_cycle();

        // random traffic; a port keeps its request steady until granted
        idle();
        gnt_prev = '0;
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 63) != 0);
            for (int p = 0; p < NP; p++) begin
                if (!(bus_if.req[p] && !gnt_prev[p])) begin
                    bus_if.req[p]           = ($urandom_range(0, 3) != 0);
                    bus_if.we[p]            = $urandom_range(0, 1);
                    bus_if.addr[p*AB +: AB] = AB'($urandom_range(0, 15));
                    bus_if.din[p*DB +: DB]  = $urandom;
                    bus_if.be[p*BB +: BB]   = BB'($urandom_range(0, 15));
                end
                bus_if.lock[p] = ($urandom_range(0, 2) == 0);
            end
            @(negedge clk);
            gnt_prev = bus_if.gnt;
            next_cycle();
        end
        rstn = 1'b1;
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
